tap_controller: RTL and testbench
=================================

TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register width (min 2).
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1000_563D, device ID; bit 0 SHALL be 1.
REQ-003 SHALL have port tck_i  input  1  TAP clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port tms_i  input  1  test mode select, sampled on rising tck_i.
REQ-006 SHALL have port tdi_i  input  1  test data input.
REQ-007 SHALL have port tdo_o  output  1  test data output (registered).
REQ-008 SHALL have port tdoEna_o  output  1  high while tdo_o carries valid shift data.
REQ-009 SHALL have port state_o  output  4  current TAP state encoding (tap_state_t).
REQ-010 SHALL have port ir_o  output  IR_WIDTH  active (updated) instruction.

Function
REQ-011 SHALL implement the 16-state IEEE 1149.1 FSM: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the six matching _IR states plus SELECT_IR.
REQ-012 SHALL take transitions per standard TMS table, one transition per rising tck_i; SELECT_IR with TMS=1 -> TEST_LOGIC_RESET.
REQ-013 SHALL reach TEST_LOGIC_RESET from any state after at most 5 consecutive TMS=1 cycles.
REQ-014 SHALL in CAPTURE_IR load IR shift register with {0..0,2'b01}.
REQ-015 SHALL in SHIFT_IR shift IR shift register right, tdi_i into MSB, LSB to tdo path.
REQ-016 SHALL in UPDATE_IR copy IR shift register to ir_o; ir_o unchanged in all other states except TEST_LOGIC_RESET.
REQ-017 SHALL decode ir_o: all-ones = BYPASS, 'b0001 = IDCODE, every other code = BYPASS.
REQ-018 SHALL in CAPTURE_DR with IDCODE load 32-bit DR shift register with IDCODE_VAL; in SHIFT_DR shift right, tdi_i into bit 31.
REQ-019 SHALL with BYPASS instantiate tap_bypass_reg, drive its bypassEna_i high exactly in SHIFT_DR, tdi_i passed through; its tdo_o selected onto the DR path.
REQ-020 SHALL register tdo_o on rising tck_i from the active shift path LSB; one-cycle latency from entering SHIFT_xR to first valid bit.
REQ-021 SHALL assert tdoEna_o the cycle after any cycle spent in SHIFT_IR or SHIFT_DR, else deassert; tdo_o SHALL be 0 when tdoEna_o low.
REQ-022 SHALL hold shift registers unchanged in PAUSE_xR, EXIT1_xR, EXIT2_xR.
REQ-023 SHALL treat entry to TEST_LOGIC_RESET (via TMS) identically to rst_i for ir_o and shift registers.

Reset
REQ-024 SHALL on rst_i=1 at rising tck_i: state TEST_LOGIC_RESET, ir_o = IDCODE, tdo_o=0, tdoEna_o=0, shift registers cleared.
REQ-025 SHALL override any in-progress shift when rst_i asserts; no UPDATE occurs.

Configuration
REQ-026 SHALL support macro TAP_IDCODE_EN.
REQ-027 SHALL with TAP_IDCODE_EN defined implement IDCODE register and reset ir_o to IDCODE.
REQ-028 SHALL without TAP_IDCODE_EN omit the 32-bit DR, decode IDCODE opcode as BYPASS, reset ir_o to all-ones.

Structure
REQ-029 SHALL place tap_state_t enum, IDCODE/BYPASS opcode constants and IR_WIDTH default in tap_pkg.
REQ-030 SHALL use tap_bypass_reg as its only sub-module; FSM, IR and IDCODE DR inline.

Verification
REQ-031 Reset: rst_i=1 one cycle -> state_o=TEST_LOGIC_RESET, ir_o=4'b0001, tdoEna_o=0.
REQ-032 Recovery: from SHIFT_DR drive TMS=1 five cycles -> state_o=TEST_LOGIC_RESET, ir_o=IDCODE.
REQ-033 IDCODE read: reset, TMS 0,1,0,0 then 32 shift cycles -> tdo_o sequence LSB-first equals 32'h1000_563D.
REQ-034 IR capture/load: shift IR with tdi 1,1,1,1 -> first two tdo_o bits 1,0; after UPDATE_IR ir_o=4'b1111.
REQ-035 Bypass: IR=BYPASS, shift tdi pattern 8'b10101011 LSB-first in SHIFT_DR -> tdo_o reproduces pattern delayed one bypass bit (first bit 0).
REQ-036 Pause: enter PAUSE_DR mid IDCODE shift for 3 cycles, resume -> remaining tdo_o bits continue without loss; undefined opcode 4'b0101 -> behaves as BYPASS.

Source files
------------

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - TAP state encoding, opcode constants and parameter defaults
package tap_pkg;

  localparam int unsigned IR_WIDTH_DEFAULT = 4;

  // Opcodes are stored wide and truncated to IR_WIDTH at the point of use
  localparam logic [31:0] OPC_IDCODE = 32'h0000_0001;
  localparam logic [31:0] OPC_BYPASS = 32'hFFFF_FFFF;

  // Encoding follows the IEEE 1149.1 state codes commonly shown on TAP diagrams
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

endpackage

// File: rtl/tap_bypass_reg.sv
// rtl/tap_bypass_reg.sv - single-bit BYPASS data register
module tap_bypass_reg (
  input  logic tck_i,
  input  logic rst_i,
  input  logic capture_i,
  input  logic bypassEna_i,
  input  logic tdi_i,
  output logic tdo_o
);

  // Capture loads 0 so the first bit out of a bypass scan is always 0
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      tdo_o <= 1'b0;
    end else if (capture_i) begin
      tdo_o <= 1'b0;
    end else if (bypassEna_i) begin
      tdo_o <= tdi_i;
    end
  end

endmodule

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP controller; TAP_IDCODE_EN adds the 32-bit IDCODE register
module tap_controller
  import tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = IR_WIDTH_DEFAULT,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_563D
) (
  input  logic                tck_i,
  input  logic                rst_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdoEna_o,
  output logic [3:0]          state_o,
  output logic [IR_WIDTH-1:0] ir_o
);

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("IR_WIDTH must be at least 2");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE_VAL bit 0 must be 1");
  end

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OPC_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OPC_BYPASS);
`endif

  tap_state_t          state;
  tap_state_t          state_next;
  logic                clear;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic                sel_idcode;
  logic                bypass_tdo;
  logic                dr_lsb;

  assign state_o = state;
  assign ir_o    = ir_q;

  // Entering TEST_LOGIC_RESET through TMS clears exactly what rst_i clears
  assign clear = rst_i || (state_next == TEST_LOGIC_RESET);

  // State register
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Standard TMS-driven next-state table
  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_next = tms_i ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_next = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  // Instruction shift register and the active instruction it feeds on UPDATE_IR
  always_ff @(posedge tck_i) begin
    if (clear) begin
      ir_sr <= '0;
      ir_q  <= IR_RESET;
    end else begin
      case (state)
        CAPTURE_IR: ir_sr <= IR_CAPTURE;
        SHIFT_IR:   ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
        UPDATE_IR:  ir_q  <= ir_sr;
        default:    ir_sr <= ir_sr;
      endcase
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] dr_sr;

  assign sel_idcode = (ir_q == IR_WIDTH'(OPC_IDCODE));
  assign dr_lsb     = sel_idcode ? dr_sr[0] : bypass_tdo;

  // IDCODE register only moves while IDCODE is the active instruction
  always_ff @(posedge tck_i) begin
    if (clear) begin
      dr_sr <= '0;
    end else if (sel_idcode && (state == CAPTURE_DR)) begin
      dr_sr <= IDCODE_VAL;
    end else if (sel_idcode && (state == SHIFT_DR)) begin
      dr_sr <= {tdi_i, dr_sr[31:1]};
    end
  end
`else
  // Without the ID register every opcode, IDCODE included, selects BYPASS
  assign sel_idcode = 1'b0;
  assign dr_lsb     = bypass_tdo;
`endif

  tap_bypass_reg u_bypass (
    .tck_i       (tck_i),
    .rst_i       (clear),
    .capture_i   ((state == CAPTURE_DR) && !sel_idcode),
    .bypassEna_i ((state == SHIFT_DR) && !sel_idcode),
    .tdi_i       (tdi_i),
    .tdo_o       (bypass_tdo)
  );

  // Registered TDO: the LSB of the shifting path, forced low outside shifts
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      tdo_o    <= 1'b0;
      tdoEna_o <= 1'b0;
    end else if (state == SHIFT_IR) begin
      tdo_o    <= ir_sr[0];
      tdoEna_o <= 1'b1;
    end else if (state == SHIFT_DR) begin
      tdo_o    <= dr_lsb;
      tdoEna_o <= 1'b1;
    end else begin
      tdo_o    <= 1'b0;
      tdoEna_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - self-checking bench for tap_controller with a queue-based scan model
module tb_tap_controller;
  import tap_pkg::*;

  localparam int          W   = 4;
  localparam logic [31:0] IDV = 32'h1000_563D;
`ifdef TAP_IDCODE_EN
  localparam bit          ID_EN = 1'b1;
`else
  localparam bit          ID_EN = 1'b0;
`endif
  localparam logic [3:0]  IR_RST = ID_EN ? 4'b0001 : 4'b1111;

  logic         tck = 1'b0;
  logic         rst = 1'b0;
  logic         tms = 1'b0;
  logic         tdi = 1'b0;
  logic         tdo;
  logic         tdo_ena;
  logic [3:0]   state;
  logic [W-1:0] ir;

  always #5 tck = ~tck;

  tap_controller #(.IR_WIDTH(W), .IDCODE_VAL(IDV)) dut (
    .tck_i    (tck),
    .rst_i    (rst),
    .tms_i    (tms),
    .tdi_i    (tdi),
    .tdo_o    (tdo),
    .tdoEna_o (tdo_ena),
    .state_o  (state),
    .ir_o     (ir)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tap_state_t  m_state;
  logic [3:0]  m_ir;
  bit          m_q[$];
  logic        m_tdo;
  logic        m_ena;
  logic [63:0] cap;
  int          ncap;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
    case (s)
      TEST_LOGIC_RESET: return t ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return t ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        return t ? SELECT_IR : CAPTURE_DR;
      SELECT_IR:        return t ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR:  return t ? EXIT1_DR : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR:  return t ? EXIT1_IR : SHIFT_IR;
      EXIT1_DR:         return t ? UPDATE_DR : PAUSE_DR;
      EXIT1_IR:         return t ? UPDATE_IR : PAUSE_IR;
      PAUSE_DR:         return t ? EXIT2_DR : PAUSE_DR;
      PAUSE_IR:         return t ? EXIT2_IR : PAUSE_IR;
      EXIT2_DR:         return t ? UPDATE_DR : SHIFT_DR;
      EXIT2_IR:         return t ? UPDATE_IR : SHIFT_IR;
      default:          return t ? SELECT_DR : RUN_TEST_IDLE;
    endcase
  endfunction

  // Scan chain as a bit queue: capture fills it, shift pops the head and appends tdi
  task automatic model_step(input logic t, input logic d, input logic r);
    if (r) begin
      m_state = TEST_LOGIC_RESET;
      m_ir    = IR_RST;
      m_q.delete();
      m_tdo   = 1'b0;
      m_ena   = 1'b0;
      return;
    end
    if (m_state == SHIFT_IR || m_state == SHIFT_DR) begin
      m_tdo = m_q.pop_front();
      m_q.push_back(d);
      m_ena = 1'b1;
    end else begin
      m_tdo = 1'b0;
      m_ena = 1'b0;
    end
    case (m_state)
      CAPTURE_IR: begin
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(i == 0);
      end
      CAPTURE_DR: begin
        m_q.delete();
        if (ID_EN && m_ir == 4'b0001) begin
          for (int i = 0; i < 32; i++) m_q.push_back(IDV[i]);
        end else begin
          m_q.push_back(1'b0);
        end
      end
      UPDATE_IR: begin
        for (int i = 0; i < W; i++) m_ir[i] = m_q[i];
      end
      default: ;
    endcase
    m_state = tap_next(m_state, t);
    if (m_state == TEST_LOGIC_RESET) begin
      m_ir = IR_RST;
      m_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("state_o", {60'd0, state}, {60'd0, m_state});
    chk("ir_o", {60'd0, ir}, {60'd0, m_ir});
    chk("tdoEna_o", {63'd0, tdo_ena}, {63'd0, m_ena});
    chk("tdo_o", {63'd0, tdo}, {63'd0, m_tdo});
  endtask

  task automatic step(input logic t, input logic d, input logic r);
    tms = t;
    tdi = d;
    rst = r;
    @(posedge tck);
    model_step(t, d, r);
    @(negedge tck);
    cyc++;
    compare();
    if (tdo_ena === 1'b1 && ncap < 64) begin
      cap[ncap] = tdo;
      ncap++;
    end
  endtask

  // From RUN_TEST_IDLE: load an instruction and return to RUN_TEST_IDLE
  task automatic load_ir(input logic [3:0] v);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    ncap = 0;
    cap  = '0;
    for (int i = 0; i < W; i++) step(i == W - 1, v[i], 0);
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  // From RUN_TEST_IDLE: scan n DR bits of pat, optionally pausing after 'brk' bits
  task automatic scan_dr(input int n, input logic [31:0] pat, input int brk);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    ncap = 0;
    cap  = '0;
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) || (i == brk - 1), pat[i], 0);
      if (i == brk - 1 && i != n - 1) begin
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
      end
    end
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  logic [31:0] pat;
  logic [31:0] exp_id;

  initial begin
    ncap = 0;
    cap  = '0;
    pat  = 32'hA5C3_0F96;
    exp_id = ID_EN ? IDV : {pat[30:0], 1'b0};

    // Reset
    step(0, 0, 1);
    chk("reset_state", {60'd0, state}, 64'hF);
    chk("reset_ir", {60'd0, ir}, {60'd0, IR_RST});
    chk("reset_tdoena", {63'd0, tdo_ena}, 64'd0);
    step(1, 0, 0);
    step(1, 0, 0);

    // IDCODE read straight after reset
    step(0, 0, 0);
    scan_dr(32, pat, 99);
    chk("idcode_read", {32'd0, cap[31:0]}, {32'd0, exp_id});

    // IR capture pattern and load of all-ones
    load_ir(4'b1111);
    chk("ir_capture_bits", {62'd0, cap[1:0]}, 64'd1);
    chk("ir_load_ones", {60'd0, ir}, 64'hF);

    // Bypass delays by one bit, first bit 0
    scan_dr(8, 32'h0000_00AB, 99);
    chk("bypass_pattern", {56'd0, cap[7:0]}, 64'h56);

    // Undefined opcode acts as bypass
    load_ir(4'b0101);
    chk("ir_load_0101", {60'd0, ir}, 64'h5);
    scan_dr(8, 32'h0000_00AB, 99);
    chk("undef_bypass", {56'd0, cap[7:0]}, 64'h56);

    // IDCODE with a three-cycle pause after ten bits
    load_ir(4'b0001);
    chk("ir_load_idcode", {60'd0, ir}, 64'h1);
    scan_dr(32, pat, 10);
    chk("idcode_paused", {32'd0, cap[31:0]}, {32'd0, exp_id});

    // Recovery from SHIFT_DR with five TMS=1 cycles
    load_ir(4'b0101);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("recover_state", {60'd0, state}, 64'hF);
    chk("recover_ir", {60'd0, ir}, {60'd0, IR_RST});

    // Reset asserted in the middle of an IR shift: no update happens
    step(0, 0, 0);
    load_ir(4'b0110);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 1);
    chk("midshift_rst_state", {60'd0, state}, 64'hF);
    chk("midshift_rst_ir", {60'd0, ir}, {60'd0, IR_RST});
    chk("midshift_rst_ena", {63'd0, tdo_ena}, 64'd0);
    step(1, 0, 0);
    step(0, 0, 0);
    load_ir(4'b1010);
    chk("ir_load_1010", {60'd0, ir}, 64'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
